// File: rtl/sequencer_spi_host.sv
// sequencer_spi_host: SPI mode-0 master for the sequencer configuration port.
// One command shifts a DATA_WIDTH-bit word out MSB first while capturing miso.
// It can then pulse latch_data. A separate request fires control_trigger.
module sequencer_spi_host #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_latch,
  input  logic                  trig_req,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss_n,
  input  logic                  miso,
  output logic                  latch_data,
  output logic                  control_trigger
);

  localparam int                BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5,
    ST_TRIG  = 3'd6
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [7:0]            cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [DATA_WIDTH-1:0] tx_r;
  logic [DATA_WIDTH-1:0] rx_r;
  logic                  latch_flag_r;

  logic term_s;
  logic timed_s;
  logic accept_s;
  logic trig_go_s;
  logic last_bit_s;
  logic rise_s;
  logic fall_s;
  logic bit_end_s;

  logic sclk_next_s;
  logic mosi_next_s;
  logic ss_n_next_s;

  // A command is taken only while idle and advertising ready; a simultaneous
  // trigger request loses to the command and is dropped.
  assign accept_s   = (state_r == ST_IDLE) && cmd_valid && cmd_ready;
  assign trig_go_s  = (state_r == ST_IDLE) && trig_req && !cmd_valid;
  assign term_s     = (cnt_r == DIV_LAST);
  assign last_bit_s = (bit_cnt_r == BIT_LAST);
  // sclk is the phase flag in SHIFT: high phase while sclk is 1.
  assign fall_s     = (state_r == ST_SHIFT) && sclk && term_s;
  assign bit_end_s  = (state_r == ST_SHIFT) && !sclk && term_s;
  assign rise_s     = sclk_next_s && !sclk;

  // Flag the states whose length is measured by the half-period counter.
  always_comb begin
    timed_s = 1'b0;
    case (state_r)
      ST_SETUP, ST_SHIFT, ST_HOLD, ST_LATCH, ST_TRIG: timed_s = 1'b1;
      default:                                        timed_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; timed states advance when the half-period counter wraps.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SETUP;
        end else if (trig_go_s) begin
          state_next_s = ST_TRIG;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (term_s) state_next_s = ST_SHIFT;
        else        state_next_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (bit_end_s && last_bit_s) state_next_s = ST_HOLD;
        else                         state_next_s = ST_SHIFT;
      end
      ST_HOLD: begin
        if (term_s && latch_flag_r)  state_next_s = ST_LATCH;
        else if (term_s)             state_next_s = ST_DONE;
        else                         state_next_s = ST_HOLD;
      end
      ST_LATCH: begin
        if (term_s) state_next_s = ST_DONE;
        else        state_next_s = ST_LATCH;
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_TRIG: begin
        if (term_s) state_next_s = ST_IDLE;
        else        state_next_s = ST_TRIG;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the SPI pins, derived from current and next state so the
  // pins themselves can be registered without glitches.
  always_comb begin
    sclk_next_s = 1'b0;
    mosi_next_s = 1'b0;
    ss_n_next_s = 1'b1;
    if (state_next_s == ST_SHIFT) begin
      if (term_s) sclk_next_s = ~sclk;
      else        sclk_next_s = sclk;
    end else begin
      sclk_next_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s) mosi_next_s = cmd_data[DATA_WIDTH-1];
        else          mosi_next_s = 1'b0;
      end
      ST_SETUP, ST_SHIFT: begin
        if (fall_s) mosi_next_s = tx_r[DATA_WIDTH-1];
        else        mosi_next_s = mosi;
      end
      default: mosi_next_s = 1'b0;
    endcase
    case (state_next_s)
      ST_SETUP, ST_SHIFT, ST_HOLD: ss_n_next_s = 1'b0;
      default:                     ss_n_next_s = 1'b1;
    endcase
  end

  // Half-period counter, bit counter and the transmit/receive shift registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r        <= 8'd0;
      bit_cnt_r    <= {BIT_W{1'b0}};
      tx_r         <= {DATA_WIDTH{1'b0}};
      rx_r         <= {DATA_WIDTH{1'b0}};
      latch_flag_r <= 1'b0;
    end else begin
      if (timed_s && !term_s) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
      if (accept_s) begin
        // MSB goes straight to mosi; tx_r holds the remaining bits, MSB-aligned.
        tx_r         <= {cmd_data[DATA_WIDTH-2:0], 1'b0};
        latch_flag_r <= cmd_latch;
        bit_cnt_r    <= {BIT_W{1'b0}};
      end else if (fall_s) begin
        tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
      end
      if (bit_end_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (rise_s) begin
        rx_r <= {rx_r[DATA_WIDTH-2:0], miso};
      end
    end
  end

  // Output registers: every port-facing output is a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk            <= 1'b0;
      mosi            <= 1'b0;
      ss_n            <= 1'b1;
      latch_data      <= 1'b0;
      control_trigger <= 1'b0;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= {DATA_WIDTH{1'b0}};
      busy            <= 1'b0;
    end else begin
      sclk            <= sclk_next_s;
      mosi            <= mosi_next_s;
      ss_n            <= ss_n_next_s;
      latch_data      <= (state_next_s == ST_LATCH);
      control_trigger <= (state_next_s == ST_TRIG);
      cmd_ready       <= (state_next_s == ST_IDLE);
      busy            <= (state_next_s != ST_IDLE);
      rsp_valid       <= (state_next_s == ST_DONE);
      if (state_next_s == ST_DONE) begin
        rsp_data <= rx_r;
      end
    end
  end

endmodule

// File: tb/tb_sequencer_spi_host.sv
// tb_sequencer_spi_host: directed bench for the sequencer SPI host.
// dut runs with CLK_DIV=2, dut1 with CLK_DIV=1 for back-to-back timing.
module tb_sequencer_spi_host;

  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic          cmd_valid, cmd_ready, cmd_latch, trig_req, rsp_valid, busy;
  logic          sclk, mosi, ss_n, miso, latch_data, control_trigger;
  logic [DW-1:0] cmd_data, rsp_data;

  logic          c1_cmd_valid, c1_cmd_ready, c1_cmd_latch, c1_trig_req, c1_rsp_valid, c1_busy;
  logic          c1_sclk, c1_mosi, c1_ss_n, c1_miso, c1_latch_data, c1_control_trigger;
  logic [DW-1:0] c1_cmd_data, c1_rsp_data;

  int   miso_mode;  // 0: tie low, 1: tie high, 2: mosi looped back one cycle late
  logic miso_lb;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  sequencer_spi_host #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_latch(cmd_latch),
    .trig_req(trig_req), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
    .latch_data(latch_data), .control_trigger(control_trigger)
  );

  sequencer_spi_host #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready), .cmd_data(c1_cmd_data), .cmd_latch(c1_cmd_latch),
    .trig_req(c1_trig_req), .rsp_valid(c1_rsp_valid), .rsp_data(c1_rsp_data), .busy(c1_busy),
    .sclk(c1_sclk), .mosi(c1_mosi), .ss_n(c1_ss_n), .miso(c1_miso),
    .latch_data(c1_latch_data), .control_trigger(c1_control_trigger)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // One-cycle-delayed copy of mosi used as a loopback slave.
  always @(posedge clock) miso_lb <= mosi;

  // Select the miso source for dut.
  always_comb begin
    if (miso_mode == 0)      miso = 1'b0;
    else if (miso_mode == 1) miso = 1'b1;
    else                     miso = miso_lb;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Offer one command to dut and watch the frame until rsp_valid (bounded).
  task automatic run_frame(input logic [31:0] data, input logic latch, input logic with_trig,
                           output int low_cnt, output int rises, output logic [31:0] mosi_seq,
                           output int rsp_cyc, output logic [31:0] rsp_word,
                           output int latch_cnt, output int latch_first, output int ss_rise,
                           output int trig_cnt);
    logic prev_sclk;
    logic prev_ss;
    low_cnt = 0; rises = 0; mosi_seq = 32'h0; rsp_cyc = -1; rsp_word = 32'h0;
    latch_cnt = 0; latch_first = -1; ss_rise = -1; trig_cnt = 0;
    @(negedge clock);
    chk1("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_data = data; cmd_latch = latch; trig_req = with_trig;
    prev_sclk = 1'b0; prev_ss = 1'b1;
    for (int n = 1; n <= 400 && rsp_cyc < 0; n++) begin
      @(negedge clock);
      if (n == 1) begin
        cmd_valid = 1'b0; trig_req = 1'b0;
        chk1("busy_after_accept", busy, 1'b1);
        chk1("ready_low_after_accept", cmd_ready, 1'b0);
      end
      if (!ss_n) low_cnt++;
      if (ss_n && !prev_ss && ss_rise < 0) ss_rise = n;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_seq = {mosi_seq[30:0], mosi};
      end
      if (latch_data) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = n;
      end
      if (control_trigger) trig_cnt++;
      if (rsp_valid) begin
        rsp_cyc  = n;
        rsp_word = rsp_data;
      end
      prev_sclk = sclk; prev_ss = ss_n;
    end
  endtask

  int lo, ri, rc, lc, lf, sr, tc, cnt, r1, r2, ss2, rise1, rise2;
  logic [31:0] ms, rw, w1;
  logic ps, pss;

  // Directed test sequence.
  initial begin
    cmd_valid = 1'b0; cmd_data = 32'h0; cmd_latch = 1'b0; trig_req = 1'b0; miso_mode = 0;
    c1_cmd_valid = 1'b0; c1_cmd_data = 32'h0; c1_cmd_latch = 1'b0; c1_trig_req = 1'b0; c1_miso = 1'b1;

    // Reset values.
    repeat (2) @(negedge clock);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_ss_n", ss_n, 1'b1);
    chk1("rst_latch", latch_data, 1'b0);
    chk1("rst_trig", control_trigger, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_data", rsp_data, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_c1_ss_n", c1_ss_n, 1'b1);
    reset = 1'b0;
    chk1("ready_before_first_edge", cmd_ready, 1'b0);
    @(negedge clock);
    chk1("ready_after_release", cmd_ready, 1'b1);

    // Frame 1: A5C30F81, loopback, no latch.
    miso_mode = 2;
    run_frame(32'hA5C3_0F81, 1'b0, 1'b0, lo, ri, ms, rc, rw, lc, lf, sr, tc);
    chk32("f1_ss_low_cycles", lo, 132);
    chk32("f1_sclk_rises", ri, 32);
    chk32("f1_mosi_bits", ms, 32'hA5C3_0F81);
    chk32("f1_rsp_cycle", rc, 133);
    chk32("f1_latch_cycles", lc, 0);
    chk32("f1_rsp_data", rw, 32'hA5C3_0F81);
    @(negedge clock);
    chk1("f1_ready_after", cmd_ready, 1'b1);
    chk1("f1_busy_after", busy, 1'b0);
    chk1("f1_rsp_valid_pulse", rsp_valid, 1'b0);
    chk32("f1_rsp_data_held", rsp_data, 32'hA5C3_0F81);

    // Frame 2: loopback of 80000001.
    run_frame(32'h8000_0001, 1'b0, 1'b0, lo, ri, ms, rc, rw, lc, lf, sr, tc);
    chk32("f2_mosi_bits", ms, 32'h8000_0001);
    chk32("f2_rsp_data", rw, 32'h8000_0001);

    // Frame 3: miso high, latched.
    miso_mode = 1;
    run_frame(32'h3C5A_96E1, 1'b1, 1'b0, lo, ri, ms, rc, rw, lc, lf, sr, tc);
    chk32("f3_ss_low_cycles", lo, 132);
    chk32("f3_ss_rise_cycle", sr, 133);
    chk32("f3_latch_first", lf, 133);
    chk32("f3_latch_cycles", lc, 2);
    chk32("f3_rsp_cycle", rc, 135);
    chk32("f3_rsp_data", rw, 32'hFFFF_FFFF);

    // Trigger alone in IDLE.
    @(negedge clock);
    trig_req = 1'b1;
    @(negedge clock);
    trig_req = 1'b0;
    chk1("trig_c1_high", control_trigger, 1'b1);
    chk1("trig_c1_busy", busy, 1'b1);
    chk1("trig_c1_ready", cmd_ready, 1'b0);
    @(negedge clock);
    chk1("trig_c2_high", control_trigger, 1'b1);
    chk1("trig_c2_busy", busy, 1'b1);
    @(negedge clock);
    chk1("trig_c3_low", control_trigger, 1'b0);
    chk1("trig_c3_idle", busy, 1'b0);

    // Trigger together with a command: command wins.
    miso_mode = 0;
    run_frame(32'h0F0F_F0F0, 1'b0, 1'b1, lo, ri, ms, rc, rw, lc, lf, sr, tc);
    chk32("tc_trig_cycles", tc, 0);
    chk32("tc_rsp_cycle", rc, 133);
    chk32("tc_rsp_data", rw, 32'h0);
    @(negedge clock);
    chk1("tc_trig_after", control_trigger, 1'b0);

    // Reset during bit 17 of a frame.
    miso_mode = 1;
    cmd_valid = 1'b1; cmd_data = 32'hDEAD_BEEF; cmd_latch = 1'b0;
    ri = 0; ps = 1'b0;
    for (int n = 1; n <= 400 && ri < 18; n++) begin
      @(negedge clock);
      if (n == 1) cmd_valid = 1'b0;
      if (sclk && !ps) ri++;
      ps = sclk;
    end
    chk32("mid_reached_bit17", ri, 18);
    reset = 1'b1;
    #1;
    chk1("mid_ss_n", ss_n, 1'b1);
    chk1("mid_sclk", sclk, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_rsp_valid", rsp_valid, 1'b0);
    chk32("mid_rsp_data", rsp_data, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clock);
      if (rsp_valid) cnt++;
    end
    chk32("mid_no_rsp", cnt, 0);
    miso_mode = 2;
    run_frame(32'h1357_9BDF, 1'b0, 1'b0, lo, ri, ms, rc, rw, lc, lf, sr, tc);
    chk32("post_rst_rsp_cycle", rc, 133);
    chk32("post_rst_rsp_data", rw, 32'h1357_9BDF);

    // CLK_DIV=1 back-to-back with cmd_valid held.
    @(negedge clock);
    c1_cmd_valid = 1'b1; c1_cmd_data = 32'hC001_D00D;
    r1 = -1; r2 = -1; ss2 = -1; rise1 = -1; rise2 = -1; w1 = 32'h0;
    ps = 1'b0; pss = 1'b1;
    for (int n = 1; n <= 400 && r2 < 0; n++) begin
      @(negedge clock);
      if (c1_sclk && !ps) begin
        if (rise1 < 0)      rise1 = n;
        else if (rise2 < 0) rise2 = n;
      end
      if (c1_rsp_valid) begin
        if (r1 < 0) begin
          r1 = n;
          w1 = c1_rsp_data;
        end else begin
          r2 = n;
        end
      end
      if (r1 >= 0 && n > r1 && !c1_ss_n && pss && ss2 < 0) ss2 = n;
      ps = c1_sclk; pss = c1_ss_n;
    end
    c1_cmd_valid = 1'b0;
    chk32("d1_rsp_cycle", r1, 67);
    chk32("d1_sclk_period", rise2 - rise1, 2);
    chk32("d1_ss_fall_gap", ss2 - r1, 2);
    chk32("d1_frame_gap", r2 - r1, 68);
    chk32("d1_rsp_data", w1, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
